// File: rtl/fp_pkg.sv
// Shared FP helpers: width table, pre-normalise state encoding, constants.
// Included by every FP block that needs EMSB/FMSB from WID.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int EXP_DENORM = 1;

    function automatic int fp_emsb(input int wid);
        case (wid)
            16:      return 4;
            32:      return 7;
            64:      return 10;
            80:      return 14;
            128:     return 14;
            default: return 7;
        endcase
    endfunction

    function automatic int fp_fmsb(input int wid);
        case (wid)
            16:      return 9;
            32:      return 22;
            64:      return 51;
            80:      return 63;
            128:     return 111;
            default: return 22;
        endcase
    endfunction

endpackage

// File: rtl/fp_lzc_step.sv
// Leading-zero count over one STEP-wide window; saturates at STEP
// when the whole window is zero.
module fp_lzc_step
    import fp_pkg::*;
#(
    parameter int STEP = 4,
    localparam int CW = $clog2(STEP) + 1
) (
    input  logic [STEP-1:0] v,
    output logic [CW-1:0]   cnt
);

    // Highest set bit wins, since it is visited last.
    always_comb begin
        cnt = CW'(STEP);
        for (int i = 0; i < STEP; i++) begin
            if (v[i]) cnt = CW'(STEP - 1 - i);
        end
    end

endmodule

// File: rtl/fp_prenorm.sv
// FP pre-normalise stage: shifts denormal fractions left until the
// hidden bit is set, tracking a widened signed exponent.
module fp_prenorm
    import fp_pkg::*;
#(
    parameter int WID  = 32,
    parameter int STEP = 4,
    localparam int EMSB = fp_emsb(WID),
    localparam int FMSB = fp_fmsb(WID)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            sgn_i,
    input  logic [EMSB:0]   exp_i,
    input  logic [FMSB+1:0] fract_i,
    input  logic            xz_i,
    input  logic            vz_i,
    input  logic            inf_i,
    input  logic            qnan_i,
    input  logic            snan_i,
    input  logic            nan_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sgn_o,
    output logic [EMSB+1:0] exp_o,
    output logic [FMSB+1:0] fract_o,
    output logic            zero_o,
    output logic            inf_o,
    output logic            qnan_o,
    output logic            snan_o,
    output logic            nan_o,
    output logic            denorm_o
);

    localparam int CW = $clog2(STEP) + 1;
    localparam int EW = EMSB + 2;

    state_t        state, nxt;
    logic [CW-1:0] lz;
    logic          full;
    logic          acc;
    logic          den;

    fp_lzc_step #(.STEP(STEP)) u_lzc (
        .v   (fract_o[FMSB+1 -: STEP]),
        .cnt (lz)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign acc       = in_valid & in_ready & ~flush_i;
    assign full      = (lz == CW'(STEP));
    assign den       = xz_i & ~vz_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (acc) nxt = den ? NORM : DONE;
            NORM:    if (!full) nxt = DONE;
            DONE:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (flush_i) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_o    <= 1'b0;
            exp_o    <= '0;
            fract_o  <= '0;
            zero_o   <= 1'b0;
            inf_o    <= 1'b0;
            qnan_o   <= 1'b0;
            snan_o   <= 1'b0;
            nan_o    <= 1'b0;
            denorm_o <= 1'b0;
        end else if (acc) begin
            sgn_o <= sgn_i;
            unique case (1'b1)
                den: begin
                    exp_o    <= EW'(EXP_DENORM);
                    fract_o  <= fract_i;
                    zero_o   <= 1'b0;
                    inf_o    <= 1'b0;
                    qnan_o   <= 1'b0;
                    snan_o   <= 1'b0;
                    nan_o    <= 1'b0;
                    denorm_o <= 1'b1;
                end
                vz_i: begin
                    exp_o    <= '0;
                    fract_o  <= '0;
                    zero_o   <= 1'b1;
                    inf_o    <= 1'b0;
                    qnan_o   <= 1'b0;
                    snan_o   <= 1'b0;
                    nan_o    <= 1'b0;
                    denorm_o <= 1'b0;
                end
                default: begin
                    exp_o    <= {1'b0, exp_i};
                    fract_o  <= fract_i;
                    zero_o   <= 1'b0;
                    inf_o    <= inf_i;
                    qnan_o   <= qnan_i;
                    snan_o   <= snan_i;
                    nan_o    <= nan_i;
                    denorm_o <= 1'b0;
                end
            endcase
        end else if (state == NORM && !flush_i) begin
            if (full) begin
                fract_o <= fract_o << STEP;
                exp_o   <= exp_o - EW'(STEP);
            end else begin
                fract_o <= fract_o << lz;
                exp_o   <= exp_o - EW'(lz);
            end
        end
    end

endmodule

// File: tb/tb_fp_prenorm.sv
// Randomised bench for fp_prenorm against a queue-based reference
// model; one negedge process checks every cycle.
module tb_fp_prenorm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sgn_i = 1'b0;
    logic [7:0]  exp_i = '0;
    logic [23:0] fract_i = '0;
    logic        xz_i = 1'b0, vz_i = 1'b0, inf_i = 1'b0;
    logic        qnan_i = 1'b0, snan_i = 1'b0, nan_i = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic        sgn_o;
    logic [8:0]  exp_o;
    logic [23:0] fract_o;
    logic        zero_o, inf_o, qnan_o, snan_o, nan_o, denorm_o;

    logic rand_rdy = 1'b0;
    logic man_rdy  = 1'b1;
    logic rnd_rdy  = 1'b1;
    assign out_ready = rand_rdy ? rnd_rdy : man_rdy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic        sgn;
        logic [7:0]  ex;
        logic [23:0] fr;
        logic        xz, vz, inf, qnan, snan, nan;
    } op_t;

    typedef struct {
        logic        sgn;
        logic [8:0]  ex;
        logic [23:0] fr;
        logic [5:0]  fl;
        int          extra;
    } res_t;

    res_t q[$];
    int   due[$];

    fp_prenorm #(.WID(32), .STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .sgn_i(sgn_i), .exp_i(exp_i), .fract_i(fract_i),
        .xz_i(xz_i), .vz_i(vz_i), .inf_i(inf_i),
        .qnan_i(qnan_i), .snan_i(snan_i), .nan_i(nan_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .sgn_o(sgn_o), .exp_o(exp_o), .fract_o(fract_o),
        .zero_o(zero_o), .inf_o(inf_o), .qnan_o(qnan_o),
        .snan_o(snan_o), .nan_o(nan_o), .denorm_o(denorm_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    // Flags are {zero, inf, qnan, snan, nan, denorm}.
    function automatic res_t model(input op_t o);
        res_t r;
        int   lz;
        r.sgn = o.sgn;
        r.extra = 0;
        if (o.xz && !o.vz) begin
            lz = 0;
            while (lz < 24 && o.fr[23-lz] == 1'b0) lz++;
            r.fr = o.fr << lz;
            r.ex = 9'(1 - lz);
            r.fl = 6'b000001;
            r.extra = lz / 4 + 1;
        end else if (o.vz) begin
            r.fr = '0;
            r.ex = '0;
            r.fl = 6'b100000;
        end else begin
            r.fr = o.fr;
            r.ex = {1'b0, o.ex};
            r.fl = {1'b0, o.inf, o.qnan, o.snan, o.nan, 1'b0};
        end
        return r;
    endfunction

    function automatic op_t mk(input logic s, input logic [7:0] e,
                               input logic [23:0] f, input int cls);
        op_t o;
        o.sgn = s; o.ex = e; o.fr = f;
        o.xz = (cls == 1 || cls == 2);
        o.vz = (cls == 2);
        o.inf = (cls == 3);
        o.qnan = (cls == 4);
        o.snan = (cls == 5);
        o.nan = (cls == 4 || cls == 5);
        return o;
    endfunction

    function automatic op_t rnd_op();
        int          c;
        logic [23:0] f;
        logic        s;
        c = $urandom_range(0, 5);
        s = 1'($urandom);
        case (c)
            0: return mk(s, 8'($urandom_range(1, 254)),
                         {1'b1, 23'($urandom)}, 0);
            1: begin
                f = 24'((32'($urandom) & 32'h7FFFFF) >> $urandom_range(0, 22));
                if (f == 0) f = 24'h1;
                return mk(s, 8'h00, f, 1);
            end
            2: return mk(s, 8'h00, 24'h0, 2);
            3: return mk(s, 8'hFF, 24'h800000, 3);
            4: return mk(s, 8'hFF, {2'b11, 22'($urandom)}, 4);
            default: begin
                f = {2'b10, 22'($urandom)};
                if (f[21:0] == 0) f[0] = 1'b1;
                return mk(s, 8'hFF, f, 5);
            end
        endcase
    endfunction

    always @(negedge clk) begin
        bit   ev;
        res_t r;
        ev = (q.size() > 0) && (cyc >= due[0]);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
        if (ev) begin
            r = q[0];
            chk("sgn_o", 32'(sgn_o), 32'(r.sgn));
            chk("exp_o", 32'(exp_o), 32'(r.ex));
            chk("fract_o", 32'(fract_o), 32'(r.fr));
            chk("flags", 32'({zero_o, inf_o, qnan_o, snan_o, nan_o,
                              denorm_o}), 32'(r.fl));
            if (out_ready) begin
                void'(q.pop_front());
                void'(due.pop_front());
            end
        end
    end

    task automatic send(input op_t o);
        bit   ok;
        res_t r;
        ok = 1'b0;
        sgn_i = o.sgn; exp_i = o.ex; fract_i = o.fr;
        xz_i = o.xz; vz_i = o.vz; inf_i = o.inf;
        qnan_i = o.qnan; snan_i = o.snan; nan_i = o.nan;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (ok) begin
            r = model(o);
            q.push_back(r);
            due.push_back(cyc + r.extra);
        end else begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready stuck at 0");
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300 && q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
            q.delete();
            due.delete();
        end
    endtask

    initial begin
        res_t r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_exp_o", 32'(exp_o), 32'h0);
        chk("rst_fract_o", 32'(fract_o), 32'h0);
        chk("rst_flags", 32'({sgn_o, zero_o, inf_o, qnan_o, snan_o,
                              nan_o, denorm_o}), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        r = model(mk(1'b0, 8'h7F, 24'h800000, 0));
        chk("pin_norm_exp", 32'(r.ex), 32'h07F);
        chk("pin_norm_lat", 32'(r.extra), 32'd0);
        r = model(mk(1'b0, 8'h00, 24'h000001, 1));
        chk("pin_den1_exp", 32'(r.ex), 32'h1EA);
        chk("pin_den1_fr", 32'(r.fr), 32'h800000);
        chk("pin_den1_lat", 32'(r.extra), 32'd6);
        r = model(mk(1'b0, 8'h00, 24'h400000, 1));
        chk("pin_den2_exp", 32'(r.ex), 32'h000);
        chk("pin_den2_lat", 32'(r.extra), 32'd1);
        r = model(mk(1'b0, 8'hFF, 24'hC00001, 4));
        chk("pin_qnan_flags", 32'(r.fl), 32'h0A);

        @(posedge clk);
        #1;
        send(mk(1'b0, 8'h7F, 24'h800000, 0));
        send(mk(1'b0, 8'h00, 24'h000001, 1));
        send(mk(1'b0, 8'h00, 24'h400000, 1));
        send(mk(1'b1, 8'h00, 24'h000000, 2));
        send(mk(1'b0, 8'hFF, 24'hC00001, 4));
        wait_idle();

        man_rdy = 1'b0;
        send(mk(1'b1, 8'h12, 24'hABCDEF, 0));
        repeat (6) @(posedge clk);
        #1;
        man_rdy = 1'b1;
        send(mk(1'b0, 8'h00, 24'h000F00, 1));
        wait_idle();

        send(mk(1'b0, 8'h00, 24'h000001, 1));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        due.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        man_rdy = 1'b0;
        send(mk(1'b0, 8'h40, 24'h900000, 0));
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        q.delete();
        due.delete();
        man_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        sgn_i = 1'b0; exp_i = 8'h33; fract_i = 24'h812345;
        xz_i = 1'b0; vz_i = 1'b0; inf_i = 1'b0;
        qnan_i = 1'b0; snan_i = 1'b0; nan_i = 1'b0;
        in_valid = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) send(rnd_op());
        wait_idle();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
